transport_tx_pacer: RTL and testbench
=====================================

TRANSPORT_TX_PACER -- requirements
Module: transport_tx_pacer

Interface
REQ-001 Parameter DEPTH, default 8, meaning: byte FIFO depth (power of 2, >=2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 wr_en  input  1  host push strobe for wr_data.
REQ-005 wr_data  input  8  byte to enqueue.
REQ-006 wr_full  output  1  FIFO full (combinational from count).
REQ-007 enable_sending  input  1  permits transmission toward the logical layer.
REQ-008 cl0_s  input  1  link in CL0 state; transmission only when high.
REQ-009 generation_speed  input  2  0=gen2, 1=gen3, 2=gen4, 3=reserved (treated as gen2).
REQ-010 transport_layer_data_in  output  8  registered byte toward the logical layer.
REQ-011 transport_data_flag  output  1  registered; high for exactly one cycle per valid byte.
REQ-012 fifo_count  output  log2(DEPTH)+1  current occupancy.
REQ-013 overflow_err  output  1  sticky; push attempted while full without same-cycle pop.

Function
REQ-014 FSM states SHALL be IDLE and SEND; go = enable_sending && cl0_s.
REQ-015 IDLE->SEND on the first edge with go=1; SEND->IDLE on the first edge with go=0.
REQ-016 Pace interval SHALL be 4 cycles (gen2/reserved), 2 cycles (gen3), 1 cycle (gen4).
REQ-017 Pace counter SHALL be 0 in IDLE and on SEND entry; the first byte may pop on the first SEND cycle.
REQ-018 In SEND, pop SHALL occur when pace counter == 0, go == 1, and fifo_count != 0.
REQ-019 On pop, counter SHALL reload to interval-1 using the generation_speed sampled that cycle; otherwise counter decrements, saturating at 0.
REQ-020 Popped byte SHALL appear on transport_layer_data_in with transport_data_flag=1 on the next cycle (latency 1).
REQ-021 When no pop occurs, transport_data_flag SHALL be 0 and transport_layer_data_in SHALL hold its last value.
REQ-022 FIFO empty in SEND: no pop, counter holds at 0, state stays SEND.
REQ-023 Push SHALL be accepted when wr_en=1 and (fifo_count<DEPTH or pop occurs that cycle).
REQ-024 Push into an empty FIFO SHALL NOT bypass: pop decision uses pre-edge occupancy only.
REQ-025 Push with fifo_count==DEPTH and no pop: byte dropped, count unchanged, overflow_err set.
REQ-026 Simultaneous accepted push and pop: count unchanged, byte order preserved (strict FIFO).
REQ-027 go falling mid-stream: no pop that cycle, FIFO contents retained, counter cleared on IDLE entry.
REQ-028 generation_speed change mid-stream SHALL take effect at the next reload only.
REQ-029 Read/write pointers SHALL wrap modulo DEPTH.

Reset
REQ-030 reset=1 SHALL immediately force: state IDLE, pointers 0, fifo_count 0, pace counter 0.
REQ-031 reset=1 SHALL immediately force transport_layer_data_in=8'h00, transport_data_flag=0, overflow_err=0, wr_full=0.
REQ-032 Reset asserted mid-stream SHALL discard all queued bytes; no flag pulse after release until new pushes.

Verification
REQ-033 gen4, go=1, push 8'hA1,8'hA2,8'hA3 back-to-back -> flag high 3 consecutive cycles, data A1,A2,A3.
REQ-034 gen2, go=1, FIFO preloaded 8'h10..8'h13 -> flag pulses every 4th cycle, data 10,11,12,13, then flag 0.
REQ-035 DEPTH=8, go=0, push 9 bytes -> fifo_count=8, wr_full=1, overflow_err=1, 9th byte never emitted.
REQ-036 gen3 streaming, drop cl0_s after 2nd byte, raise 5 cycles later -> no flag while low, 3rd byte is next queued byte, no loss/duplication.
REQ-037 Full FIFO, go=1 gen4, push each cycle for 20 cycles -> count stays 8, overflow_err=0, output order equals push order.
REQ-038 Assert reset with 5 bytes queued mid-SEND -> outputs 0 same cycle, fifo_count=0, no flag after release.

Source files
------------

// File: rtl/transport_tx_pacer.sv
// transport_tx_pacer: byte FIFO that trickles queued bytes toward the logical
// layer at a generation-dependent pace, only while sending is enabled and the
// link sits in CL0.
module transport_tx_pacer #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [7:0]                 wr_data,
    output logic                       wr_full,
    input  logic                       enable_sending,
    input  logic                       cl0_s,
    input  logic [1:0]                 generation_speed,
    output logic [7:0]                 transport_layer_data_in,
    output logic                       transport_data_flag,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [1:0]    pace_cnt;
    logic [1:0]    reload_val;
    logic          go;
    logic          pop;
    logic          push;
    logic          overflow_now;

    // Transmission permission and the pacing reload for the current generation
    always_comb begin
        go = enable_sending && cl0_s;
        case (generation_speed)
            2'd1:    reload_val = 2'd1;   // gen3: every 2 cycles
            2'd2:    reload_val = 2'd0;   // gen4: every cycle
            default: reload_val = 2'd3;   // gen2 and reserved: every 4 cycles
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic: follow go directly
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go)  state_nxt = SEND;
            SEND:    if (!go) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pop/push decisions; pop uses pre-edge occupancy so a push never bypasses
    always_comb begin
        wr_full      = (fifo_count == FULL_CNT);
        pop          = (state == SEND) && go && (pace_cnt == 2'd0) && (fifo_count != '0);
        push         = wr_en && (!wr_full || pop);
        overflow_now = wr_en && wr_full && !pop;
    end

    // Pace counter: cleared outside SEND, reloaded on pop, otherwise saturating decrement
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pace_cnt <= '0;
        end else if (state != SEND || !go) begin
            pace_cnt <= '0;
        end else if (pop) begin
            pace_cnt <= reload_val;
        end else if (pace_cnt != 2'd0) begin
            pace_cnt <= pace_cnt - 2'd1;
        end
    end

    // FIFO storage; contents need no reset since pointers and count gate visibility
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at a power-of-2 depth
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Registered output byte with a one-cycle valid flag; data holds between pops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            transport_layer_data_in <= '0;
            transport_data_flag     <= 1'b0;
        end else begin
            transport_data_flag <= pop;
            if (pop) transport_layer_data_in <= mem[rd_ptr];
        end
    end

    // Sticky overflow flag for pushes dropped on a full FIFO
    always_ff @(posedge clk or posedge reset) begin
        if (reset)             overflow_err <= 1'b0;
        else if (overflow_now) overflow_err <= 1'b1;
    end

endmodule

// File: tb/tb_transport_tx_pacer.sv
// Directed testbench for transport_tx_pacer with hand-computed expectations.
module tb_transport_tx_pacer;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       wr_full;
    logic       enable_sending;
    logic       cl0_s;
    logic [1:0] generation_speed;
    logic [7:0] transport_layer_data_in;
    logic       transport_data_flag;
    logic [3:0] fifo_count;
    logic       overflow_err;

    int n_vec;
    int n_err;

    transport_tx_pacer #(.DEPTH(8)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .wr_en                   (wr_en),
        .wr_data                 (wr_data),
        .wr_full                 (wr_full),
        .enable_sending          (enable_sending),
        .cl0_s                   (cl0_s),
        .generation_speed        (generation_speed),
        .transport_layer_data_in (transport_layer_data_in),
        .transport_data_flag     (transport_data_flag),
        .fifo_count              (fifo_count),
        .overflow_err            (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic       ef;
        logic [7:0] ed;

        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        wr_en = 1'b0;
        wr_data = 8'h00;
        enable_sending = 1'b0;
        cl0_s = 1'b1;
        generation_speed = 2'd0;

        // Reset state
        #2;
        chk("rst_data",  transport_layer_data_in, 8'h00);
        chk("rst_flag",  transport_data_flag, 1'b0);
        chk("rst_count", fifo_count, 4'd0);
        chk("rst_full",  wr_full, 1'b0);
        chk("rst_ovf",   overflow_err, 1'b0);
        step();
        step();
        reset = 1'b0;
        step();

        // gen4 back-to-back pushes, no bypass into an empty FIFO
        enable_sending = 1'b1;
        generation_speed = 2'd2;
        step();
        wr_en = 1'b1; wr_data = 8'hA1; step();
        chk("g4_nobypass_flag", transport_data_flag, 1'b0);
        chk("g4_nobypass_cnt", fifo_count, 4'd1);
        wr_data = 8'hA2; step();
        chk("g4_b1_flag", transport_data_flag, 1'b1);
        chk("g4_b1_data", transport_layer_data_in, 8'hA1);
        wr_data = 8'hA3; step();
        chk("g4_b2_flag", transport_data_flag, 1'b1);
        chk("g4_b2_data", transport_layer_data_in, 8'hA2);
        wr_en = 1'b0; step();
        chk("g4_b3_flag", transport_data_flag, 1'b1);
        chk("g4_b3_data", transport_layer_data_in, 8'hA3);
        chk("g4_b3_cnt", fifo_count, 4'd0);

        // gen2 preload 10..13 while idle, then pace every 4th cycle
        enable_sending = 1'b0;
        step();
        chk("g4_end_flag", transport_data_flag, 1'b0);
        chk("g4_end_hold", transport_layer_data_in, 8'hA3);
        wr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = 8'h10 + 8'(i);
            step();
        end
        wr_en = 1'b0;
        chk("g2_preload_cnt", fifo_count, 4'd4);
        generation_speed = 2'd0;
        enable_sending = 1'b1;
        ed = 8'hA3;
        for (int k = 0; k < 17; k++) begin
            step();
            ef = (k >= 1) && (k <= 13) && (((k - 1) % 4) == 0);
            if (ef) ed = 8'h10 + 8'((k - 1) / 4);
            chk("g2_flag", transport_data_flag, ef);
            chk("g2_data", transport_layer_data_in, ed);
        end
        chk("g2_empty_cnt", fifo_count, 4'd0);

        // Overflow while idle: ninth push is dropped
        enable_sending = 1'b0;
        wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_data = 8'h20 + 8'(i);
            step();
        end
        chk("ovf_8_cnt", fifo_count, 4'd8);
        chk("ovf_8_full", wr_full, 1'b1);
        chk("ovf_8_err", overflow_err, 1'b0);
        wr_data = 8'h28;
        step();
        wr_en = 1'b0;
        chk("ovf_9_cnt", fifo_count, 4'd8);
        chk("ovf_9_full", wr_full, 1'b1);
        chk("ovf_9_err", overflow_err, 1'b1);
        generation_speed = 2'd2;
        enable_sending = 1'b1;
        ed = 8'h13;
        for (int k = 0; k < 11; k++) begin
            step();
            ef = (k >= 1) && (k <= 8);
            if (ef) ed = 8'h20 + 8'(k - 1);
            chk("ovf_drain_flag", transport_data_flag, ef);
            chk("ovf_drain_data", transport_layer_data_in, ed);
        end
        chk("ovf_drain_cnt", fifo_count, 4'd0);

        // gen3 stream interrupted by cl0_s low for 5 cycles
        enable_sending = 1'b0;
        wr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = 8'h30 + 8'(i);
            step();
        end
        wr_en = 1'b0;
        generation_speed = 2'd1;
        enable_sending = 1'b1;
        ed = 8'h27;
        for (int k = 0; k < 15; k++) begin
            cl0_s = !((k >= 4) && (k <= 8));
            step();
            ef = (k == 1) || (k == 3) || (k == 10) || (k == 12);
            if (k == 1)  ed = 8'h30;
            if (k == 3)  ed = 8'h31;
            if (k == 10) ed = 8'h32;
            if (k == 12) ed = 8'h33;
            chk("cl0_flag", transport_data_flag, ef);
            chk("cl0_data", transport_layer_data_in, ed);
        end
        chk("cl0_cnt", fifo_count, 4'd0);

        // Clear sticky overflow, then full FIFO with simultaneous push/pop at gen4
        reset = 1'b1;
        #1;
        chk("rst2_ovf", overflow_err, 1'b0);
        step();
        reset = 1'b0;
        enable_sending = 1'b0;
        wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_data = 8'h40 + 8'(i);
            step();
        end
        wr_en = 1'b0;
        generation_speed = 2'd2;
        enable_sending = 1'b1;
        step();
        chk("full_enter_cnt", fifo_count, 4'd8);
        wr_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            wr_data = 8'h48 + 8'(k);
            step();
            chk("full_flag", transport_data_flag, 1'b1);
            chk("full_data", transport_layer_data_in, 8'h40 + 8'(k));
            chk("full_cnt", fifo_count, 4'd8);
        end
        wr_en = 1'b0;
        chk("full_ovf", overflow_err, 1'b0);

        // Reset mid-stream with 5 bytes queued
        for (int k = 0; k < 3; k++) step();
        chk("mid_cnt", fifo_count, 4'd5);
        chk("mid_data", transport_layer_data_in, 8'h56);
        #2;
        reset = 1'b1;
        #1;
        chk("mrst_data", transport_layer_data_in, 8'h00);
        chk("mrst_flag", transport_data_flag, 1'b0);
        chk("mrst_cnt", fifo_count, 4'd0);
        chk("mrst_full", wr_full, 1'b0);
        step();
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("post_rst_flag", transport_data_flag, 1'b0);
            chk("post_rst_cnt", fifo_count, 4'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
